div: RTL and testbench
======================

# div

Sequential 32-bit signed integer divider serving the multicycle CPU's `div` instruction; it is the counterpart of the `Mult` unit. It sits beside `Mult` and drives the `DivHiOut`/`DivLoOut` inputs of the HI/LO source muxes and the `DivZero` exception input of the control unit. It uses a restoring shift-subtract algorithm on operand magnitudes, one quotient bit per cycle, followed by a sign fix-up cycle.

## Interface
- No parameters. Width is fixed at 32.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high. Sampled on the rising edge of `clk`.
- `divStart` in 1: start request from the control unit. Sampled only in IDLE.
- `A` in 32: dividend, two's complement; sourced from register A.
- `B` in 32: divisor, two's complement; sourced from register B.
- `DivHiOut` out 32: remainder, registered.
- `DivLoOut` out 32: quotient, registered.
- `DivZero` out 1: divide-by-zero flag, registered.
- `divDone` out 1: one-cycle completion pulse, registered.

## Operation
- States are IDLE, RUN, FIX. Internal state:
  - `rem` 33 b: partial remainder.
  - `quo` 32 b: dividend magnitude, shifted left into the quotient.
  - `dvs` 32 b: divisor magnitude.
  - `cnt` 6 b: iteration counter.
  - `sq`: quotient sign, equal to A[31]^B[31].
  - `sr`: remainder sign, equal to A[31].
- IDLE with `divStart`=1 and `B`≠0:
  - Latch `quo`=|A|, `dvs`=|B|, `rem`=0, `cnt`=0, `sq`, `sr`.
  - Clear `DivZero`.
  - Go to RUN.
  - Magnitudes are unsigned 32-bit, so |0x80000000| = 0x80000000.
- IDLE with `divStart`=1 and `B`=0:
  - Set `DivZero`=1 and stay in IDLE.
  - `DivHiOut` and `DivLoOut` are unchanged. No `divDone`.
  - `DivZero` stays high until the next accepted `divStart` or until reset.
- RUN, each cycle:
  - t = {rem[31:0], quo[31]}.
  - If t ≥ {1'b0, dvs}: rem = t − dvs and the shifted-in quotient bit is 1.
  - Otherwise: rem = t and the shifted-in quotient bit is 0.
  - quo = {quo[30:0], bit}, and `cnt` increments.
  - After 32 iterations (cnt reaches 32), go to FIX.
- FIX:
  - `DivLoOut` = `sq` ? −quo : quo.
  - `DivHiOut` = `sr` ? −rem[31:0] : rem[31:0].
  - `divDone`=1 for one cycle. Return to IDLE.
- Results follow MIPS semantics: the quotient truncates toward zero, and the remainder takes the dividend's sign.
- Overflow case 0x80000000 / 0xFFFFFFFF: `DivLoOut`=0x80000000, `DivHiOut`=0. No flag is raised.
- `divStart` in RUN or FIX is ignored. Operand changes after the start edge are ignored.
- `divStart` in the same cycle that `divDone` is high is accepted, because the block is already in IDLE.

## Timing
- Reset values: `DivHiOut`=0, `DivLoOut`=0, `DivZero`=0, `divDone`=0, state IDLE, `cnt`=0.
- Reset has priority over all other activity, including mid-RUN. There is no partial result write.
- Latency, with the start edge labelled E0:
  - RUN iterations occur on edges E1..E32.
  - The FIX write occurs on E33.
  - New `DivHiOut`/`DivLoOut` and `divDone`=1 are visible from E33 until E34.
  - `divDone` falls at E34. Results hold until the next completion or reset.
- Divide-by-zero: `DivZero` is visible after E0, i.e. in the cycle following the start request.
- Throughput: one division per 34 cycles when starts are back-to-back.
- No combinational path from inputs to outputs.

## Test plan
- A=7, B=2, pulse `divStart` at E0 → at E33: `DivLoOut`=3, `DivHiOut`=1, `divDone`=1 for exactly one cycle, `DivZero`=0.
- A=−7 (0xFFFFFFF9), B=2 → `DivLoOut`=0xFFFFFFFD, `DivHiOut`=0xFFFFFFFF. Repeat with A=7, B=−2 → `DivLoOut`=0xFFFFFFFD, `DivHiOut`=1.
- Prior result 3/1 held; then A=5, B=0 with start → `DivZero`=1 after E0 and stays high; `DivLoOut`=3 and `DivHiOut`=1 unchanged; no `divDone` within 40 cycles. A following A=9, B=3 start clears `DivZero`.
- A=0x80000000, B=0xFFFFFFFF → `DivLoOut`=0x80000000, `DivHiOut`=0 at E33. Also cover A=0x80000000, B=1 → `DivLoOut`=0x80000000, `DivHiOut`=0.
- Start A=100, B=7. Toggle `divStart` and change A/B during E5–E20 → result is unaffected: `DivLoOut`=14, `DivHiOut`=2 at E33, with a single `divDone`.
- Start A=100, B=7. Assert `reset` at E10 → all outputs are 0 on the next cycle and no `divDone` appears. A restart of A=100, B=7 afterwards completes normally 33 edges later with 14/2.

Source files
------------

// File: rtl/div_if.sv
// Operand, start and result bundle between the control unit and the divider.
interface div_if;
    logic        divStart;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] DivHiOut;
    logic [31:0] DivLoOut;
    logic        DivZero;
    logic        divDone;

    // Control unit side: issues the start request and operands, reads results.
    modport master (
        output divStart, A, B,
        input  DivHiOut, DivLoOut, DivZero, divDone
    );

    // Divider side.
    modport slave (
        input  divStart, A, B,
        output DivHiOut, DivLoOut, DivZero, divDone
    );
endinterface

// File: rtl/div.sv
// Sequential 32-bit signed divider for the div instruction.
// Restoring shift-subtract on operand magnitudes, one quotient bit per cycle,
// followed by a single sign fix-up cycle. HI gets the remainder, LO the quotient.
module div (
    input  logic  clk,
    input  logic  reset,
    div_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t      state_q, state_d;
    // The partial remainder always stays below the divisor magnitude, so only
    // the trial value t needs the extra 33rd bit.
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sq_q, sq_d;
    logic        sr_q, sr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;

    logic [32:0] t;
    logic        qbit;

    // State and datapath registers; reset wins over any in-flight division.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath: accept/reject in IDLE, iterate in RUN, sign-fix in FIX.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        t       = {rem_q, quo_q[31]};
        qbit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.divStart) begin
                    if (bus.B != 32'd0) begin
                        quo_d   = bus.A[31] ? (32'd0 - bus.A) : bus.A;
                        dvs_d   = bus.B[31] ? (32'd0 - bus.B) : bus.B;
                        rem_d   = '0;
                        cnt_d   = '0;
                        sq_d    = bus.A[31] ^ bus.B[31];
                        sr_d    = bus.A[31];
                        zero_d  = 1'b0;
                        state_d = RUN;
                    end else begin
                        zero_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (t >= {1'b0, dvs_q}) begin
                    rem_d = t[31:0] - dvs_q;
                    qbit  = 1'b1;
                end else begin
                    rem_d = t[31:0];
                    qbit  = 1'b0;
                end
                quo_d = {quo_q[30:0], qbit};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = sq_q ? (32'd0 - quo_q) : quo_q;
                hi_d    = sr_q ? (32'd0 - rem_q) : rem_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.DivHiOut = hi_q;
    assign bus.DivLoOut = lo_q;
    assign bus.DivZero  = zero_q;
    assign bus.divDone  = done_q;

endmodule

// File: tb/tb_div.sv
// Directed plus random checks of the sequential signed divider.
module tb_div;

    logic clk;
    logic reset;

    div_if bus();

    div dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int testsRun;
    int testsFailed;

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: MIPS signed division done in 64-bit arithmetic, which truncates
    // toward zero, keeps the dividend's sign on the remainder, and absorbs the
    // 0x80000000 / -1 overflow (its low 32 bits give 0x80000000 / 0).
    function automatic logic [31:0] refQuo(input logic [31:0] a, input logic [31:0] b);
        longint q;
        q = longint'($signed(a)) / longint'($signed(b));
        return q[31:0];
    endfunction

    function automatic logic [31:0] refRem(input logic [31:0] a, input logic [31:0] b);
        longint r;
        r = longint'($signed(a)) % longint'($signed(b));
        return r[31:0];
    endfunction

    // Present operands with a one-cycle start pulse; returns after the start edge E0.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        bus.A        = a;
        bus.B        = b;
        bus.divStart = 1'b1;
        tick();
        bus.divStart = 1'b0;
    endtask

    // Wait (bounded) for divDone and check latency and results; stays on the done cycle.
    task automatic waitAndCheck(input logic [31:0] a, input logic [31:0] b, input string tag);
        int edges;
        edges = 0;
        while (bus.divDone !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checkOutput({tag, "_latency"}, 32'(edges), 32'd33);
        checkOutput({tag, "_lo"}, bus.DivLoOut, refQuo(a, b));
        checkOutput({tag, "_hi"}, bus.DivHiOut, refRem(a, b));
        checkOutput({tag, "_zero"}, {31'd0, bus.DivZero}, 32'd0);
    endtask

    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input string tag);
        applyStimulus(a, b);
        waitAndCheck(a, b, tag);
        tick();
        checkOutput({tag, "_donefall"}, {31'd0, bus.divDone}, 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_hi"}, bus.DivHiOut, 32'd0);
        checkOutput({tag, "_lo"}, bus.DivLoOut, 32'd0);
        checkOutput({tag, "_zero"}, {31'd0, bus.DivZero}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, bus.divDone}, 32'd0);
    endtask

    // Directed sequence followed by random operands.
    initial begin
        int doneCount;
        int doneEdge;
        logic [31:0] seenLo;
        logic [31:0] seenHi;
        logic        zeroHeld;
        logic [31:0] ra;
        logic [31:0] rb;

        testsRun     = 0;
        testsFailed  = 0;
        bus.divStart = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        reset        = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkAllZero("reset");

        runDiv(32'd7, 32'd2, "pos_7_2");
        checkOutput("pos_7_2_lo_const", bus.DivLoOut, 32'd3);
        runDiv(32'hFFFF_FFF9, 32'd2, "neg_dividend");
        runDiv(32'd7, 32'hFFFF_FFFE, "neg_divisor");

        // Divide by zero keeps prior results, never completes, flag sticks.
        runDiv(32'd7, 32'd2, "prior");
        applyStimulus(32'd5, 32'd0);
        checkOutput("dz_flag", {31'd0, bus.DivZero}, 32'd1);
        checkOutput("dz_lo_held", bus.DivLoOut, 32'd3);
        checkOutput("dz_hi_held", bus.DivHiOut, 32'd1);
        doneCount = 0;
        zeroHeld  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.divDone === 1'b1) doneCount++;
            if (bus.DivZero !== 1'b1) zeroHeld = 1'b0;
        end
        checkOutput("dz_no_done", 32'(doneCount), 32'd0);
        checkOutput("dz_sticky", {31'd0, zeroHeld}, 32'd1);
        applyStimulus(32'd9, 32'd3);
        checkOutput("dz_cleared", {31'd0, bus.DivZero}, 32'd0);
        waitAndCheck(32'd9, 32'd3, "after_dz");
        tick();

        runDiv(32'h8000_0000, 32'hFFFF_FFFF, "overflow");
        checkOutput("overflow_lo_const", bus.DivLoOut, 32'h8000_0000);
        runDiv(32'h8000_0000, 32'd1, "min_by_one");

        // Start and operand churn during the run must not disturb the result.
        applyStimulus(32'd100, 32'd7);
        doneCount = 0;
        doneEdge  = 0;
        seenLo    = '0;
        seenHi    = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k >= 5 && k <= 20) begin
                bus.divStart = k[0];
                bus.A        = $urandom;
                bus.B        = $urandom;
            end else begin
                bus.divStart = 1'b0;
            end
            tick();
            if (bus.divDone === 1'b1) begin
                doneCount++;
                if (doneEdge == 0) begin
                    doneEdge = k;
                    seenLo   = bus.DivLoOut;
                    seenHi   = bus.DivHiOut;
                end
            end
        end
        checkOutput("churn_done_count", 32'(doneCount), 32'd1);
        checkOutput("churn_done_edge", 32'(doneEdge), 32'd33);
        checkOutput("churn_lo", seenLo, 32'd14);
        checkOutput("churn_hi", seenHi, 32'd2);

        // Reset in mid-run abandons the division without a write.
        applyStimulus(32'd100, 32'd7);
        for (int k = 1; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkAllZero("midrun_reset");
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.divDone === 1'b1) doneCount++;
        end
        checkOutput("midrun_no_done", 32'(doneCount), 32'd0);
        runDiv(32'd100, 32'd7, "restart");

        // A start on the done cycle is accepted immediately.
        applyStimulus(32'd20, 32'd3);
        waitAndCheck(32'd20, 32'd3, "chain_first");
        applyStimulus(32'hFFFF_FFCE, 32'd6);
        checkOutput("chain_done_drop", {31'd0, bus.divDone}, 32'd0);
        waitAndCheck(32'hFFFF_FFCE, 32'd6, "chain_second");
        tick();

        // Random operands, mixing full-range and small divisors.
        for (int n = 0; n < 10; n++) begin
            ra = $urandom;
            rb = n[0] ? $urandom : {{28{ra[3]}}, 4'(1 + $urandom_range(0, 14))};
            if (rb == 32'd0) rb = 32'd1;
            runDiv(ra, rb, "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
